// File: rtl/sdram_dma.sv
// rtl/sdram_dma.sv - pipelined SDRAM-to-SDRAM copy engine with read-data FIFO and credit-limited reads
// Optional fill mode (fill_mode/fill_pattern ports) is compiled in with `define SDRAM_DMA_FILL_EN.
module sdram_dma #(
    parameter int DATA_W          = 32,
    parameter int ADDR_W          = 32,
    parameter int FIFO_DEPTH      = 8,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dest_addr,
    input  logic [31:0]       num_words,
    input  logic              enable,
`ifdef SDRAM_DMA_FILL_EN
    input  logic              fill_mode,
    input  logic [DATA_W-1:0] fill_pattern,
`endif
    output logic              busy,
    output logic              done,
    input  logic              master_waitrequest,
    output logic [ADDR_W-1:0] master_address,
    output logic              master_read,
    input  logic [DATA_W-1:0] master_readdata,
    input  logic              master_readdatavalid,
    output logic              master_write,
    output logic [DATA_W-1:0] master_writedata
);

    localparam int BYTES = DATA_W / 8;
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t            state_q, state_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              read_q, read_d;
    logic              write_q, write_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [ADDR_W-1:0] src_q, src_d;
    logic [ADDR_W-1:0] dest_q, dest_d;
    logic [31:0]       num_q, num_d;
    logic              fill_q, fill_d;
    logic [DATA_W-1:0] pattern_q, pattern_d;
    logic [31:0]       rd_cnt_q, rd_cnt_d;
    logic [31:0]       wr_cnt_q, wr_cnt_d;
    logic [31:0]       outst_q, outst_d;
    logic [31:0]       fcount_q, fcount_d;
    logic [PTR_W-1:0]  rptr_q, rptr_d;
    logic [PTR_W-1:0]  wptr_q, wptr_d;

    logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];

    logic              rd_acc, wr_acc, push, pop, issue, can_read;
    logic [31:0]       rd_cnt_n, wr_cnt_n, outst_n, fcount_n, fifo_avail;
    logic [PTR_W-1:0]  head_idx;
    logic [ADDR_W-1:0] rd_off, wr_off;
    logic              fill_start;
    logic [DATA_W-1:0] pattern_start;

`ifdef SDRAM_DMA_FILL_EN
    assign fill_start    = fill_mode;
    assign pattern_start = fill_pattern;
`else
    assign fill_start    = 1'b0;
    assign pattern_start = '0;
`endif

    assign busy             = busy_q;
    assign done             = done_q;
    assign master_read      = read_q;
    assign master_write     = write_q;
    assign master_address   = addr_q;
    assign master_writedata = wdata_q;

    always_comb begin
        rd_acc     = read_q && !master_waitrequest;
        wr_acc     = write_q && !master_waitrequest;
        push       = (state_q == S_RUN) && master_readdatavalid;
        pop        = wr_acc && !fill_q;
        rd_cnt_n   = rd_cnt_q + 32'(rd_acc);
        wr_cnt_n   = wr_cnt_q + 32'(wr_acc);
        outst_n    = outst_q + 32'(rd_acc) - 32'(push);
        fcount_n   = fcount_q + 32'(push) - 32'(pop);
        // Entries left after this cycle's pop; a same-cycle push is forwarded from readdata.
        fifo_avail = fcount_q - 32'(pop);
        head_idx   = rptr_q + PTR_W'(pop);
        rd_off     = ADDR_W'(rd_cnt_n) * ADDR_W'(BYTES);
        wr_off     = ADDR_W'(wr_cnt_n) * ADDR_W'(BYTES);
        can_read   = (rd_cnt_n < num_q) && (outst_n < 32'(MAX_OUTSTANDING))
                     && ((outst_n + fcount_n) < 32'(FIFO_DEPTH));
        issue      = (!read_q && !write_q) || rd_acc || wr_acc;

        state_d   = state_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        read_d    = read_q;
        write_d   = write_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        src_d     = src_q;
        dest_d    = dest_q;
        num_d     = num_q;
        fill_d    = fill_q;
        pattern_d = pattern_q;
        rd_cnt_d  = rd_cnt_n;
        wr_cnt_d  = wr_cnt_n;
        outst_d   = outst_n;
        fcount_d  = fcount_n;
        rptr_d    = rptr_q + PTR_W'(pop);
        wptr_d    = wptr_q + PTR_W'(push);

        case (state_q)
            S_IDLE: begin
                if (enable) begin
                    src_d     = src_addr;
                    dest_d    = dest_addr;
                    num_d     = num_words;
                    fill_d    = fill_start;
                    pattern_d = pattern_start;
                    rd_cnt_d  = '0;
                    wr_cnt_d  = '0;
                    if (num_words == 32'd0) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_RUN;
                        busy_d  = 1'b1;
                        if (fill_start) begin
                            write_d = 1'b1;
                            addr_d  = dest_addr;
                            wdata_d = pattern_start;
                        end else begin
                            read_d = 1'b1;
                            addr_d = src_addr;
                        end
                    end
                end
            end
            S_RUN: begin
                if (issue) begin
                    read_d  = 1'b0;
                    write_d = 1'b0;
                    if (wr_cnt_n == num_q && outst_n == 32'd0) begin
                        state_d = S_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else if (fill_q) begin
                        write_d = 1'b1;
                        addr_d  = dest_q + wr_off;
                        wdata_d = pattern_q;
                    end else if (fifo_avail != 32'd0 || push) begin
                        write_d = 1'b1;
                        addr_d  = dest_q + wr_off;
                        wdata_d = (fifo_avail != 32'd0) ? fifo_mem[head_idx] : master_readdata;
                    end else if (can_read) begin
                        read_d = 1'b1;
                        addr_d = src_q + rd_off;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                read_d  = 1'b0;
                write_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            read_q    <= 1'b0;
            write_q   <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            src_q     <= '0;
            dest_q    <= '0;
            num_q     <= '0;
            fill_q    <= 1'b0;
            pattern_q <= '0;
            rd_cnt_q  <= '0;
            wr_cnt_q  <= '0;
            outst_q   <= '0;
            fcount_q  <= '0;
            rptr_q    <= '0;
            wptr_q    <= '0;
        end else begin
            state_q   <= state_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            read_q    <= read_d;
            write_q   <= write_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            src_q     <= src_d;
            dest_q    <= dest_d;
            num_q     <= num_d;
            fill_q    <= fill_d;
            pattern_q <= pattern_d;
            rd_cnt_q  <= rd_cnt_d;
            wr_cnt_q  <= wr_cnt_d;
            outst_q   <= outst_d;
            fcount_q  <= fcount_d;
            rptr_q    <= rptr_d;
            wptr_q    <= wptr_d;
        end
    end

    // Storage needs no reset: the pointers define which entries are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wptr_q] <= master_readdata;
        end
    end

endmodule
